// File: rtl/bit_dup_pipe.sv
// Streaming bit-replication unit: each accepted WIDTH-bit word is expanded per its mode
// and held in a 2-entry elastic buffer, with accept and error counters alongside.
module bit_dup_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REPS  = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned RW   = $clog2(REPS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_mode,
    input  logic [RW-1:0]          in_reps,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*REPS-1:0]  out_data,
    output logic [1:0]             out_mode,
    output logic [CNT_W-1:0]       accept_count,
    output logic [7:0]             err_count
);

    localparam int unsigned OW = WIDTH * REPS;

    logic [OW-1:0]    w_exp;
    logic [1:0]       w_mode;
    logic             w_err;
    logic [31:0]      w_r;
    logic             w_push;
    logic             w_pop;

    logic [OW-1:0]    r_data [2];
    logic [1:0]       r_mode [2];
    logic             r_rd;
    logic             r_wr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_acc;
    logic [7:0]       r_err;

    // Expansion of the incoming word; stored at accept so the head never changes.
    always_comb begin
        w_exp  = '0;
        w_mode = in_mode;
        w_err  = 1'b0;
        w_r    = REPS;
        case (in_mode)
            2'd1: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_exp[i*REPS +: REPS] = {REPS{in_data[i]}};
                end
            end
            2'd2: begin
                if (in_reps == '0 || 32'(in_reps) > REPS) begin
                    w_mode = 2'd0;
                    w_err  = 1'b1;
                end else begin
                    w_r = 32'(in_reps);
                end
                for (int unsigned k = 0; k < REPS; k++) begin
                    if (k < w_r) begin
                        w_exp[k*WIDTH +: WIDTH] = in_data;
                    end
                end
            end
            2'd3: begin
                w_exp  = {REPS{in_data}};
                w_mode = 2'd0;
                w_err  = 1'b1;
            end
            default: w_exp = {REPS{in_data}};
        endcase
    end

    assign in_ready     = (r_count != 2'd2);
    assign out_valid    = (r_count != 2'd0);
    assign out_data     = r_data[r_rd];
    assign out_mode     = r_mode[r_rd];
    assign accept_count = r_acc;
    assign err_count    = r_err;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_ready & out_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_mode[0] <= '0;
            r_mode[1] <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_count   <= 2'd0;
            r_acc     <= '0;
            r_err     <= 8'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= w_exp;
                r_mode[r_wr] <= w_mode;
                r_wr         <= ~r_wr;
                r_acc        <= r_acc + CNT_W'(1);
                if (w_err && r_err != 8'hFF) begin
                    r_err <= r_err + 8'd1;
                end
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
